sysid_info_regs: RTL and testbench
==================================

// Module: sysid_info_regs
// PURPOSE
//  Parametrised system-ID/info slave: successor to the 2-word combinational sysid. Avalon-MM
//  slave on the system interconnect that returns ID, build timestamp, version and feature words,
//  and adds a 64-bit uptime counter with tear-free snapshot, a scratch register and control/status.
//  Read data is registered with fixed latency 1 (readdatavalid). Software polls it at boot/debug.
// PARAMETERS
//  ADDR_W      3             word-address width, >=3; offsets >=8 are unmapped
//  SYSTEM_ID   32'h0000_0000 value at offset 0
//  TIMESTAMP   32'h0000_0000 build time (epoch seconds) at offset 1
//  VER_MAJOR   16'd1         offset 2 bits[31:16]
//  VER_MINOR   16'd0         offset 2 bits[15:0]
//  FEATURES    32'h0         feature bitmap at offset 3
//  TICK_DIV    1             uptime increments once per TICK_DIV clocks, range 1..65535
//  SCRATCH_RST 32'h0         scratch reset value
// PORTS
//  clock          in   1       system clock
//  reset_n        in   1       synchronous, active-low reset
//  address        in   ADDR_W  word address
//  read           in   1       read strobe, single-cycle, no waitrequest
//  write          in   1       write strobe, single-cycle, no waitrequest
//  writedata      in   32      write data
//  byteenable     in   4       byte lanes for write
//  readdata       out  32      registered read data
//  readdatavalid  out  1       high exactly one cycle after an accepted read
// BEHAVIOUR
//  Reset (reset_n=0 at clock edge): readdata=0, readdatavalid=0, uptime=0, prescaler=0,
//   shadow_hi=0, scratch=SCRATCH_RST, frozen=0, ro_err=0.
//  Map: 0 ID | 1 TIMESTAMP | 2 {VER_MAJOR,VER_MINOR} | 3 FEATURES | 4 UPTIME_LO | 5 UPTIME_HI
//   (shadow) | 6 SCRATCH (RW) | 7 CTRL/STATUS | >=8 reads 0.
//  Read: read=1 at edge N -> readdata/readdatavalid valid at edge N+1; readdatavalid low otherwise;
//   readdata holds last value when not reading. Back-to-back reads every cycle are supported.
//  Snapshot: a read of offset 4 returns uptime[31:0] as sampled at edge N and, in the same edge,
//   loads shadow_hi<=uptime[63:32]. Offset 5 returns shadow_hi (not the live counter).
//  Uptime: prescaler counts 0..TICK_DIV-1; uptime+=1 on the cycle prescaler==TICK_DIV-1, unless
//   frozen. Prescaler does not advance while frozen. 64-bit wrap to 0, no flag.
//  Write: write=1 at edge N takes effect at edge N (visible to a read at edge N+1).
//   SCRATCH: per-byte update by byteenable; byteenable=0 -> no change.
//   CTRL (only if byteenable[0]): bit0=1 clears uptime and prescaler (self-clearing, reads 0);
//    bit1 writes frozen; bit2=1 clears ro_err (W1C).
//   Offsets 0-5 and >=8: data dropped, ro_err<=1 (sticky).
//  STATUS read (offset 7): {29'b0, ro_err, frozen, 1'b0}.
//  Simultaneous: read & write same cycle -> write performed, read ignored (no readdatavalid).
//   Clear and tick same cycle -> uptime=0 (clear wins). ro_err set and CTRL bit2 clear in the same
//   write cannot occur (offsets differ).
//  Reset mid-read: readdatavalid for a read accepted before reset is suppressed (0 after reset).
// STRUCTURE
//  sysid_pkg: register offset localparams (OFF_ID..OFF_CTRL), CTRL/STATUS bit positions,
//   REG_W=32, UPTIME_W=64.
//  Sub-module sysid_uptime_counter: prescaler + 64-bit counter; inputs clear, freeze;
//   outputs count[63:0]. Top holds decode, scratch, shadow, status and the read register.
// TESTING
//  1 SYSTEM_ID=32'h550F_FAC9: read off 0 -> readdata=32'h550F_FAC9, readdatavalid 1 cycle later only.
//  2 Tear-free: force uptime to 64'h0000_0001_FFFF_FFFF, read off 4 then off 5 across tick ->
//    LO=32'hFFFF_FFFF, HI=1 (not 2).
//  3 Scratch: write 32'hDEAD_BEEF be=4'b1111, write 32'h0000_0012 be=4'b0001 -> read 32'hDEAD_BE12.
//  4 CTRL: TICK_DIV=4, run 40 clocks -> LO=10; write CTRL=2 (freeze), wait 20 -> unchanged;
//    write CTRL=1 -> LO=0; write CTRL=0 -> resumes at 1 after 4 clocks.
//  5 RO write: write off 0 and off 9 -> STATUS=32'h4, ID unchanged; write CTRL=4 -> STATUS=0.
//  6 Reset: assert reset_n=0 the cycle after a read -> readdatavalid=0, scratch=SCRATCH_RST, uptime=0.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID/info slave: register offsets,
// CTRL/STATUS bit positions and datapath widths.
package sysid_pkg;

    localparam int REG_W    = 32;
    localparam int UPTIME_W = 64;
    localparam int PRESC_W  = 16;

    localparam logic [2:0] OFF_ID    = 3'd0;
    localparam logic [2:0] OFF_TS    = 3'd1;
    localparam logic [2:0] OFF_VER   = 3'd2;
    localparam logic [2:0] OFF_FEAT  = 3'd3;
    localparam logic [2:0] OFF_UPLO  = 3'd4;
    localparam logic [2:0] OFF_UPHI  = 3'd5;
    localparam logic [2:0] OFF_SCR   = 3'd6;
    localparam logic [2:0] OFF_CTRL  = 3'd7;

    localparam int CTRL_CLR   = 0;
    localparam int CTRL_FRZ   = 1;
    localparam int CTRL_W1C   = 2;

    localparam int STS_FROZEN = 1;
    localparam int STS_ROERR  = 2;

endpackage

// File: rtl/sysid_uptime_counter.sv
// Prescaled 64-bit uptime counter with synchronous clear and freeze.
// Ports: clock, reset_n (sync, active-low), clear, freeze -> count[63:0].
module sysid_uptime_counter
    import sysid_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                freeze,
    output logic [UPTIME_W-1:0] count
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0]  r_presc;
    logic [UPTIME_W-1:0] r_count;

    // Clear has priority over a tick landing on the same edge.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            r_presc <= '0;
            r_count <= '0;
        end else if (!freeze) begin
            if (r_presc == LAST) begin
                r_presc <= '0;
                r_count <= r_count + UPTIME_W'(1);
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
        end
    end

    assign count = r_count;

endmodule

// File: rtl/sysid_info_regs.sv
// Avalon-MM system-ID/info slave: ID, timestamp, version, features,
// uptime with tear-free snapshot, scratch and CTRL/STATUS registers.
// Ports: clock, reset_n (sync, active-low), address, read, write,
// writedata, byteenable -> readdata, readdatavalid (latency 1).
module sysid_info_regs
    import sysid_pkg::*;
#(
    parameter int unsigned      ADDR_W      = 3,
    parameter logic [31:0]      SYSTEM_ID   = 32'h0000_0000,
    parameter logic [31:0]      TIMESTAMP   = 32'h0000_0000,
    parameter logic [15:0]      VER_MAJOR   = 16'd1,
    parameter logic [15:0]      VER_MINOR   = 16'd0,
    parameter logic [31:0]      FEATURES    = 32'h0,
    parameter int unsigned      TICK_DIV    = 1,
    parameter logic [31:0]      SCRATCH_RST = 32'h0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [REG_W-1:0]  writedata,
    input  logic [3:0]        byteenable,
    output logic [REG_W-1:0]  readdata,
    output logic              readdatavalid
);

    logic [REG_W-1:0]    r_scratch;
    logic [REG_W-1:0]    r_shadow_hi;
    logic                r_frozen;
    logic                r_ro_err;

    logic [UPTIME_W-1:0] w_count;
    logic [2:0]          w_off;
    logic                w_mapped;
    logic                w_rd;
    logic                w_wr_scr;
    logic                w_wr_ctrl;
    logic                w_wr_ro;
    logic                w_clear;
    logic [REG_W-1:0]    w_status;
    logic [REG_W-1:0]    w_rdata;

    assign w_off     = address[2:0];
    assign w_mapped  = (address >> 3) == '0;
    // A write in the same cycle swallows the read.
    assign w_rd      = read && !write;
    assign w_wr_scr  = write && w_mapped && (w_off == OFF_SCR);
    assign w_wr_ctrl = write && w_mapped && (w_off == OFF_CTRL)
                       && byteenable[0];
    assign w_wr_ro   = write && (!w_mapped || (w_off <= OFF_UPHI));
    assign w_clear   = w_wr_ctrl && writedata[CTRL_CLR];

    sysid_uptime_counter #(
        .TICK_DIV (TICK_DIV)
    ) u_uptime (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (w_clear),
        .freeze  (r_frozen),
        .count   (w_count)
    );

    always_comb begin
        w_status             = '0;
        w_status[STS_FROZEN] = r_frozen;
        w_status[STS_ROERR]  = r_ro_err;
    end

    always_comb begin
        w_rdata = '0;
        if (w_mapped) begin
            case (w_off)
                OFF_ID:   w_rdata = SYSTEM_ID;
                OFF_TS:   w_rdata = TIMESTAMP;
                OFF_VER:  w_rdata = {VER_MAJOR, VER_MINOR};
                OFF_FEAT: w_rdata = FEATURES;
                OFF_UPLO: w_rdata = w_count[31:0];
                OFF_UPHI: w_rdata = r_shadow_hi;
                OFF_SCR:  w_rdata = r_scratch;
                OFF_CTRL: w_rdata = w_status;
                default:  w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            r_shadow_hi   <= '0;
            r_scratch     <= SCRATCH_RST;
            r_frozen      <= 1'b0;
            r_ro_err      <= 1'b0;
        end else begin
            readdatavalid <= w_rd;
            if (w_rd) begin
                readdata <= w_rdata;
            end
            // Latch the upper half with the low-word read so the pair
            // is coherent even if a carry lands in between.
            if (w_rd && w_mapped && (w_off == OFF_UPLO)) begin
                r_shadow_hi <= w_count[63:32];
            end
            if (w_wr_scr) begin
                for (int i = 0; i < 4; i++) begin
                    if (byteenable[i]) begin
                        r_scratch[8*i +: 8] <= writedata[8*i +: 8];
                    end
                end
            end
            if (w_wr_ctrl) begin
                r_frozen <= writedata[CTRL_FRZ];
                if (writedata[CTRL_W1C]) begin
                    r_ro_err <= 1'b0;
                end
            end
            if (w_wr_ro) begin
                r_ro_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sysid_info_regs.sv
// Directed scoreboard bench for sysid_info_regs.
// Expected read data is queued at issue and checked on readdatavalid.
module tb_sysid_info_regs;

    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [3:0]    byteenable;
    logic [31:0]   readdata;
    logic          readdatavalid;

    int            vectors = 0;
    int            miscompares = 0;
    logic [31:0]   exp_q[$];

    always #5 clock = ~clock;

    sysid_info_regs #(
        .ADDR_W      (AW),
        .SYSTEM_ID   (32'h550F_FAC9),
        .TIMESTAMP   (32'h6543_2100),
        .VER_MAJOR   (16'd2),
        .VER_MINOR   (16'd7),
        .FEATURES    (32'h0000_00F3),
        .TICK_DIV    (4),
        .SCRATCH_RST (32'hA5A5_0000)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        logic [31:0] e;
        @(posedge clock);
        #1;
        read  = 1'b0;
        write = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, " rdv"}, 32'(readdatavalid), 32'd1);
            chk({tag, " data"}, readdata, e);
        end else begin
            chk({tag, " rdv"}, 32'(readdatavalid), 32'd0);
        end
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] e,
                      input string tag);
        address = a;
        read    = 1'b1;
        exp_q.push_back(e);
        step(tag);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] be, input string tag);
        address    = a;
        write      = 1'b1;
        writedata  = d;
        byteenable = be;
        step(tag);
    endtask

    task automatic idle(input int n);
        repeat (n) step("idle");
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = '0;
        step("reset0");
        step("reset1");
        chk("reset readdata", readdata, 32'h0);
        reset_n = 1'b1;

        // Uptime with TICK_DIV=4, freeze, clear, resume
        idle(40);
        rd(4'd4, 32'd10, "uplo after 40");
        wr(4'd7, 32'd2, 4'hF, "ctrl freeze");
        idle(20);
        rd(4'd4, 32'd10, "uplo frozen");
        rd(4'd7, 32'h2, "status frozen");
        wr(4'd7, 32'd1, 4'hF, "ctrl clear");
        rd(4'd4, 32'd0, "uplo cleared");
        wr(4'd7, 32'd0, 4'hF, "ctrl run");
        rd(4'd4, 32'd0, "uplo pre tick");
        idle(1);
        rd(4'd4, 32'd1, "uplo first tick");

        // Constant words, back-to-back
        rd(4'd0, 32'h550F_FAC9, "id");
        rd(4'd1, 32'h6543_2100, "timestamp");
        rd(4'd2, 32'h0002_0007, "version");
        rd(4'd3, 32'h0000_00F3, "features");
        chk("readdata hold", readdata, 32'h0000_00F3);

        // Scratch byte lanes and read/write collision
        wr(4'd6, 32'hDEAD_BEEF, 4'hF, "scr full");
        wr(4'd6, 32'h0000_0012, 4'h1, "scr byte0");
        rd(4'd6, 32'hDEAD_BE12, "scr merged");
        wr(4'd6, 32'hFFFF_FFFF, 4'h0, "scr be0");
        rd(4'd6, 32'hDEAD_BE12, "scr be0 kept");
        address    = 4'd6;
        read       = 1'b1;
        write      = 1'b1;
        writedata  = 32'h1111_1111;
        byteenable = 4'b1000;
        step("rd+wr");
        rd(4'd6, 32'h11AD_BE12, "scr after rd+wr");
        rd(4'd7, 32'h0, "status clean");

        // Tear-free snapshot across a carry into the upper word
        wr(4'd7, 32'd3, 4'hF, "ctrl clr+frz");
        force dut.u_uptime.r_count = 64'h0000_0001_FFFF_FFFF;
        #1;
        release dut.u_uptime.r_count;
        wr(4'd7, 32'd0, 4'hF, "ctrl unfreeze");
        rd(4'd4, 32'hFFFF_FFFF, "snap lo");
        idle(4);
        rd(4'd5, 32'h1, "snap hi");
        rd(4'd4, 32'h0, "snap lo2");
        rd(4'd5, 32'h2, "snap hi2");

        // Read-only / unmapped writes set sticky error, W1C clears
        wr(4'd0, 32'h1234_5678, 4'hF, "wr id");
        wr(4'd9, 32'hFFFF_FFFF, 4'hF, "wr unmapped");
        rd(4'd7, 32'h4, "status ro_err");
        rd(4'd0, 32'h550F_FAC9, "id intact");
        rd(4'd9, 32'h0, "unmapped rd");
        wr(4'd7, 32'd4, 4'hF, "ctrl w1c");
        rd(4'd7, 32'h0, "status cleared");
        wr(4'd7, 32'd2, 4'h0, "ctrl be0");
        rd(4'd7, 32'h0, "ctrl be0 ignored");

        // Reset right after an accepted read
        rd(4'd6, 32'h11AD_BE12, "pre reset rd");
        reset_n = 1'b0;
        step("reset mid");
        chk("reset mid data", readdata, 32'h0);
        reset_n = 1'b1;
        rd(4'd6, 32'hA5A5_0000, "scr reset val");
        rd(4'd4, 32'h0, "uplo reset");
        rd(4'd5, 32'h0, "uphi reset");
        rd(4'd7, 32'h0, "status reset");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
